// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A-style PIC read/write control path.
package pic_pkg;

  typedef enum logic [2:0] {
    UNINIT,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } pic_state_e;

  localparam logic [1:0] RSEL_IRR = 2'b00;
  localparam logic [1:0] RSEL_ISR = 2'b01;
  localparam logic [1:0] RSEL_IMR = 2'b10;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_LTIM = 3;
  localparam int CMD_D4    = 4;
  localparam int OCW_D3    = 3;
  localparam int OCW3_P    = 2;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_RIS  = 0;

  typedef struct packed {
    logic icw1;
    logic icw2;
    logic icw3;
    logic icw4;
    logic ocw1;
    logic ocw2;
    logic ocw3;
    logic poll;
  } wr_strb_t;

  function automatic logic is_icw1(input logic a0, input logic [7:0] d);
    return !a0 && d[CMD_D4];
  endfunction

endpackage

// File: rtl/rw_write_capture.sv
// Write-strobe edge detect and data/a0 latch; optional 2-flop strobe sync
// when RW_SYNC_INPUTS_EN is defined.
module rw_write_capture (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] din,
  output logic       commit,
  output logic [7:0] data_q,
  output logic       a0_q
);

  logic wr_s;
  logic wr_act_q;
  logic blk_q;

`ifdef RW_SYNC_INPUTS_EN
  logic [1:0] cs_sync;
  logic [1:0] wr_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync <= 2'b11;
      wr_sync <= 2'b11;
    end else begin
      cs_sync <= {cs_sync[0], cs_n};
      wr_sync <= {wr_sync[0], wr_n};
    end
  end

  assign wr_s = !cs_sync[1] && !wr_sync[1];
`else
  assign wr_s = !cs_n && !wr_n;
`endif

  // blk_q masks a write already in progress when reset releases, so it never commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_act_q <= 1'b0;
      blk_q    <= 1'b1;
      data_q   <= 8'h00;
      a0_q     <= 1'b0;
    end else begin
      blk_q    <= blk_q && wr_s;
      wr_act_q <= wr_s && !blk_q;
      if (wr_s) begin
        data_q <= din;
        a0_q   <= a0;
      end
    end
  end

  assign commit = wr_act_q && !wr_s;

endmodule

// File: rtl/rw_control_logic.sv
// PIC read/write control: strobe decode, ICW1..ICW4 init FSM, OCW decode.
// Optional input synchronizers under RW_SYNC_INPUTS_EN.
module rw_control_logic
  import pic_pkg::*;
#(
  parameter logic [1:0] RESET_READ_SEL = 2'b00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] Ds_to_W_R,
  output logic       RD_flag,
  output logic       WR_flag,
  output logic [7:0] cmd_data,
  output logic       icw1_wr,
  output logic       icw2_wr,
  output logic       icw3_wr,
  output logic       icw4_wr,
  output logic       ocw1_wr,
  output logic       ocw2_wr,
  output logic       ocw3_wr,
  output logic       init_done,
  output logic       sngl,
  output logic       ic4,
  output logic       ltim,
  output logic [1:0] rd_reg_sel,
  output logic       poll_cmd
);

  logic       commit;
  logic [7:0] data_q;
  logic       a0_q;

  pic_state_e state_q, state_d;
  wr_strb_t   strb_q, strb_d;
  logic       sngl_q, sngl_d;
  logic       ic4_q, ic4_d;
  logic       ltim_q, ltim_d;
  logic [1:0] rsel_q, rsel_d;
  logic [7:0] cmd_q;

  assign WR_flag = !cs_n && !wr_n;
  assign RD_flag = !cs_n && !rd_n && !WR_flag;

  rw_write_capture u_cap (
    .clk    (clk),
    .rst_n  (rst_n),
    .cs_n   (cs_n),
    .wr_n   (wr_n),
    .a0     (a0),
    .din    (Ds_to_W_R),
    .commit (commit),
    .data_q (data_q),
    .a0_q   (a0_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNINIT;
      strb_q  <= '0;
      sngl_q  <= 1'b0;
      ic4_q   <= 1'b0;
      ltim_q  <= 1'b0;
      rsel_q  <= RESET_READ_SEL;
      cmd_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      strb_q  <= strb_d;
      sngl_q  <= sngl_d;
      ic4_q   <= ic4_d;
      ltim_q  <= ltim_d;
      rsel_q  <= rsel_d;
      if (commit) cmd_q <= data_q;
    end
  end

  always_comb begin
    state_d = state_q;
    strb_d  = '0;
    sngl_d  = sngl_q;
    ic4_d   = ic4_q;
    ltim_d  = ltim_q;
    rsel_d  = rsel_q;
    if (commit) begin
      if (is_icw1(a0_q, data_q)) begin
        strb_d.icw1 = 1'b1;
        sngl_d      = data_q[ICW1_SNGL];
        ic4_d       = data_q[ICW1_IC4];
        ltim_d      = data_q[ICW1_LTIM];
        rsel_d      = RESET_READ_SEL;
        state_d     = WAIT_ICW2;
      end else if (a0_q) begin
        case (state_q)
          WAIT_ICW2: begin
            strb_d.icw2 = 1'b1;
            state_d = !sngl_q ? WAIT_ICW3 : (ic4_q ? WAIT_ICW4 : READY);
          end
          WAIT_ICW3: begin
            strb_d.icw3 = 1'b1;
            state_d = ic4_q ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: begin
            strb_d.icw4 = 1'b1;
            state_d = READY;
          end
          READY:   strb_d.ocw1 = 1'b1;
          default: ;
        endcase
      end else if (state_q == READY) begin
        // a0=0, D4=0 before init completes falls through: no strobe, no state change.
        if (data_q[OCW_D3]) begin
          strb_d.ocw3 = 1'b1;
          strb_d.poll = data_q[OCW3_P];
          if (data_q[OCW3_RR]) rsel_d = {1'b0, data_q[OCW3_RIS]};
        end else begin
          strb_d.ocw2 = 1'b1;
        end
      end
    end
  end

  assign cmd_data   = cmd_q;
  assign icw1_wr    = strb_q.icw1;
  assign icw2_wr    = strb_q.icw2;
  assign icw3_wr    = strb_q.icw3;
  assign icw4_wr    = strb_q.icw4;
  assign ocw1_wr    = strb_q.ocw1;
  assign ocw2_wr    = strb_q.ocw2;
  assign ocw3_wr    = strb_q.ocw3;
  assign poll_cmd   = strb_q.poll;
  assign init_done  = (state_q == READY);
  assign sngl       = sngl_q;
  assign ic4        = ic4_q;
  assign ltim       = ltim_q;
  assign rd_reg_sel = rsel_q;

endmodule
